// File: rtl/joypad_pkg.sv
// Shared CPU-bus constants and types for the $4016/$4017 controller port.
package joypad_pkg;

  localparam logic [15:0] ADDR_JOY1        = 16'h4016;
  localparam logic [15:0] ADDR_JOY2        = 16'h4017;
  localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'h40;

  typedef enum logic [1:0] {
    PULSE_IDLE = 2'd0,
    PULSE_LOW  = 2'd1,
    PULSE_GAP  = 2'd2
  } pulse_state_e;

  // Upper three bits float to the open-bus value; only D0 carries controller data.
  function automatic logic [7:0] read_byte(input logic [7:0] open_bus, input logic bit0);
    return {open_bus[7:5], 4'b0000, bit0};
  endfunction

endpackage

// File: rtl/joypad_clk_gen.sv
// Per-port shift-clock generator: turns each end-of-read into one active-low pulse,
// queuing at most one extra pulse and flagging any read edge that had to be dropped.
module joypad_clk_gen
  import joypad_pkg::*;
#(
  parameter int CLK_LOW_CYCLES = 1
) (
  input  logic clock,
  input  logic nreset,
  input  logic rd_n,
  output logic clk_n,
  output logic overrun_evt
);

  localparam logic [2:0] LOW_LOAD = 3'(CLK_LOW_CYCLES - 1);

  pulse_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         pend_q, pend_d;
  logic         rd_n_q, rd_n_d;
  logic         clk_n_q, clk_n_d;
  logic         end_read;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    rd_n_d      = rd_n;
    overrun_evt = 1'b0;
    end_read    = rd_n & ~rd_n_q;

    case (state_q)
      PULSE_IDLE: begin
        if (end_read) begin
          state_d = PULSE_LOW;
          cnt_d   = LOW_LOAD;
        end
      end
      PULSE_LOW: begin
        if (cnt_q == 3'd0) begin
          state_d = PULSE_GAP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
        if (end_read) begin
          if (pend_q) overrun_evt = 1'b1;
          else        pend_d      = 1'b1;
        end
      end
      PULSE_GAP: begin
        // An edge landing in the gap with nothing queued is served straight away,
        // so the pending flag can never be stranded in IDLE.
        if (pend_q) begin
          state_d     = PULSE_LOW;
          cnt_d       = LOW_LOAD;
          pend_d      = 1'b0;
          overrun_evt = end_read;
        end else if (end_read) begin
          state_d = PULSE_LOW;
          cnt_d   = LOW_LOAD;
        end else begin
          state_d = PULSE_IDLE;
        end
      end
      default: begin
        state_d = PULSE_IDLE;
      end
    endcase

    clk_n_d = (state_d != PULSE_LOW);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= PULSE_IDLE;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
      rd_n_q  <= 1'b1;
      clk_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rd_n_q  <= rd_n_d;
      clk_n_q <= clk_n_d;
    end
  end

  assign clk_n = clk_n_q;

endmodule

// File: rtl/joypad_port.sv
// $4016/$4017 controller responder: latch register, input synchronizers, read mux,
// and two shift-clock generators. Read data is combinational from the strobes.
module joypad_port
  import joypad_pkg::*;
#(
  parameter logic [7:0] OPEN_BUS       = OPEN_BUS_DEFAULT,
  parameter int         SYNC_STAGES    = 2,
  parameter int         CLK_LOW_CYCLES = 1
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       naddr4016r,
  input  logic       naddr4017r,
  input  logic       addr4016w,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       joy_strobe,
  output logic       joy1_clk_n,
  output logic       joy2_clk_n,
  input  logic       joy1_data_n,
  input  logic       joy2_data_n,
  output logic       overrun
);

  logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
  logic [SYNC_STAGES-1:0] sync2_q, sync2_d;
  logic                   joy_strobe_q, joy_strobe_d;
  logic                   overrun_q, overrun_d;
  logic                   sync1, sync2;
  logic                   rd2_n;
  logic                   ovr1_evt, ovr2_evt;
  logic                   unused_data;

  assign unused_data = ^data_in[7:1];
  assign sync1       = sync1_q[SYNC_STAGES-1];
  assign sync2       = sync2_q[SYNC_STAGES-1];

  // Port 1 wins a simultaneous read, so port 2 only sees its own strobe when port 1 is idle.
  assign rd2_n = naddr4017r | ~naddr4016r;

  always_comb begin
    sync1_d      = {sync1_q[SYNC_STAGES-2:0], joy1_data_n};
    sync2_d      = {sync2_q[SYNC_STAGES-2:0], joy2_data_n};
    joy_strobe_d = addr4016w ? data_in[0] : joy_strobe_q;
    overrun_d    = overrun_q | ovr1_evt | ovr2_evt;

    data_out = 8'h00;
    if (!naddr4016r)      data_out = read_byte(OPEN_BUS, ~sync1);
    else if (!naddr4017r) data_out = read_byte(OPEN_BUS, ~sync2);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      joy_strobe_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      joy_strobe_q <= joy_strobe_d;
      overrun_q    <= overrun_d;
    end
  end

  joypad_clk_gen #(.CLK_LOW_CYCLES(CLK_LOW_CYCLES)) u_clk_gen1 (
    .clock       (clock),
    .nreset      (nreset),
    .rd_n        (naddr4016r),
    .clk_n       (joy1_clk_n),
    .overrun_evt (ovr1_evt)
  );

  joypad_clk_gen #(.CLK_LOW_CYCLES(CLK_LOW_CYCLES)) u_clk_gen2 (
    .clock       (clock),
    .nreset      (nreset),
    .rd_n        (rd2_n),
    .clk_n       (joy2_clk_n),
    .overrun_evt (ovr2_evt)
  );

  assign joy_strobe = joy_strobe_q;
  assign overrun    = overrun_q;

endmodule
